fm_demod_scheduler: RTL
=======================

Name: fm_demod_scheduler

Overview:
Time-multiplexed FM discriminator for NCH baseband channels that share one signed W x W multiplier. A round-robin arbiter accepts one (I,Q) sample at a time and keeps per-channel I_last/Q_last history. It computes m = I*Q_last - Q*I_last in two multiplier passes and presents the result on a valid/ready output stream tagged with the channel number. It sits between the per-channel I/Q sources and the audio/decimation back end.

Parameters:
NCH, 4, number of channels (2..8)
W, 8, sample width, signed two's complement
CW, $clog2(NCH), channel-id width (derived, not overridable)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
ch_en  in  NCH  per-channel enable; a disabled channel is never granted
hist_clr  in  1  one-cycle pulse; zeroes all I_last/Q_last history
in_valid  in  NCH  per-channel sample valid
in_ready  out  NCH  per-channel accept, one-hot or zero
in_i  in  NCH*W  I samples; channel k occupies bits [k*W +: W]
in_q  in  NCH*W  Q samples; same packing as in_i
out_valid  out  1  result valid
out_ready  in  1  downstream accept
out_m  out  2W  signed discriminator result
out_ch  out  CW  channel of out_m

Behaviour:
- Reset: state=IDLE, rr_ptr=0, all history=0, out_valid=0, out_m=0, out_ch=0, in_ready=0. rst overrides everything, including mid-operation; an in-flight sample is discarded and no output is produced for it.
- FSM states: IDLE -> MUL1 -> MUL2 -> OUT -> IDLE.
- IDLE:
  - Candidate set = in_valid & ch_en.
  - Grant = first set channel, searching from rr_ptr upward with wrap-around.
  - in_ready[grant]=1, combinational, asserted only in IDLE. All other in_ready bits are 0.
  - On the transfer edge: latch I,Q,ch; set rr_ptr=grant+1 mod NCH; go to MUL1.
  - If the candidate set is empty, stay in IDLE and leave rr_ptr unchanged.
- MUL1: p1 <= I * Q_last[ch]. This is a signed 2W-bit product on the shared multiplier.
- MUL2:
  - out_m <= p1 - Q * I_last[ch], on the same shared multiplier.
  - Wrap-free: products lie in [-16256, 16384] and the difference lies in [-32640, 32640], which fits in 2W signed bits.
  - I_last[ch] <= I, Q_last[ch] <= Q.
  - out_ch <= ch; go to OUT.
- OUT:
  - out_valid=1. out_m and out_ch are held stable until out_ready=1.
  - On out_valid&out_ready: out_valid <= 0 and return to IDLE.
- Latency: out_valid rises 3 cycles after the in_valid&in_ready edge.
- Throughput: at most 1 sample per 4 cycles.
- No sample is accepted while a result is pending.
- The shared multiplier is used exactly once per MUL state. Exactly one multiplier instance exists.
- First sample on a channel after reset or hist_clr sees zero history, so m=0.
- hist_clr:
  - Applies in any state. History is zero from the next cycle.
  - If it coincides with the MUL2 history write, the clear wins.
  - A sample in MUL1/MUL2 computes with whatever history is present that cycle: cleared history if hist_clr was pulsed earlier, otherwise the old values.
- ch_en deasserted for a channel: its in_valid is ignored and in_ready stays 0. Its history is retained.
- Source rule: in_valid/in_i/in_q must hold until accepted. The bench checks that the block never samples data without in_ready.

Test Plan:
- Ch0 sample (I=10,Q=20), then (I=30,Q=-5), out_ready=1 → first out_m=0, out_ch=0. Second out_m=30*20-(-5*10)=650. Each out_valid is exactly 3 cycles after acceptance.
- All 4 channels valid continuously with ch_en=4'hF → grants in order 0,1,2,3,0,…. in_ready is always one-hot. Successive acceptances are exactly 4 cycles apart.
- Ch1 sample (-128,127), then (-128,-128) → second out_m=-16256-16384=-32640 (0x8080), out_ch=1. No wrap.
- out_ready held low 5 cycles in OUT → out_valid stays 1, out_m/out_ch are stable, and in_ready stays 0 throughout. Acceptance resumes one cycle after the out_ready handshake.
- hist_clr pulsed between two ch2 samples (5,5) and (7,3) → second out_m=0. ch_en[3]=0 with in_valid[3]=1 → in_ready[3] is never asserted.
- rst asserted during MUL2 → next cycle all outputs are at reset values. No out_valid for the aborted sample. The next sample on that channel yields m=0.

Source files
------------

// File: rtl/fm_demod_scheduler.sv
// Time-multiplexed FM discriminator: NCH I/Q channels share one signed
// W x W multiplier. A round-robin arbiter takes one sample at a time and
// m = I*Q_last - Q*I_last is formed over two multiplier passes, then
// presented on a valid/ready stream tagged with the channel number.
module fm_demod_scheduler #(
    parameter int NCH = 4,
    parameter int W   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCH-1:0]          ch_en,
    input  logic                    hist_clr,
    input  logic [NCH-1:0]          in_valid,
    output logic [NCH-1:0]          in_ready,
    input  logic [NCH*W-1:0]        in_i,
    input  logic [NCH*W-1:0]        in_q,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*W-1:0]          out_m,
    output logic [$clog2(NCH)-1:0]  out_ch
);
    localparam int CW = $clog2(NCH);

    typedef enum logic [1:0] {IDLE, MUL1, MUL2, OUT} state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       rr_ptr;
    logic [CW-1:0]       grant;
    logic                grant_vld;
    logic [CW:0]         idx;
    logic [CW-1:0]       ch;
    logic signed [W-1:0] i_r, q_r;
    logic signed [W-1:0] i_last [NCH];
    logic signed [W-1:0] q_last [NCH];
    logic signed [W-1:0] mul_a, mul_b;
    logic [2*W-1:0]      prod;
    logic [2*W-1:0]      p1;

    // Round-robin search from rr_ptr upward; iterating backwards lets the
    // nearest candidate win. idx is one bit wider so the wrap needs no modulo.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        idx       = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr} + (CW+1)'(k);
            if (idx >= (CW+1)'(NCH))
                idx = idx - (CW+1)'(NCH);
            if (in_valid[idx[CW-1:0]] && ch_en[idx[CW-1:0]]) begin
                grant     = idx[CW-1:0];
                grant_vld = 1'b1;
            end
        end
    end

    // Next-state and handshake outputs; in_ready is only offered in IDLE.
    always_comb begin
        state_nxt = state;
        in_ready  = '0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                if (grant_vld && !rst) begin
                    in_ready[grant] = 1'b1;
                    state_nxt       = MUL1;
                end
            end
            MUL1: state_nxt = MUL2;
            MUL2: state_nxt = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Single shared multiplier: pass 1 is I*Q_last, pass 2 is Q*I_last.
    // Operands are sign-extended so the low 2W bits are the signed product.
    always_comb begin
        mul_a = (state == MUL2) ? q_r : i_r;
        mul_b = (state == MUL2) ? i_last[ch] : q_last[ch];
        prod  = {{W{mul_a[W-1]}}, mul_a} * {{W{mul_b[W-1]}}, mul_b};
    end

    // Datapath: sample capture, product accumulation, history update.
    // hist_clr is applied last so it overrides the MUL2 history write.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            ch     <= '0;
            i_r    <= '0;
            q_r    <= '0;
            p1     <= '0;
            out_m  <= '0;
            out_ch <= '0;
            for (int k = 0; k < NCH; k++) begin
                i_last[k] <= '0;
                q_last[k] <= '0;
            end
        end else begin
            if (state == IDLE && grant_vld) begin
                i_r    <= in_i[grant*W +: W];
                q_r    <= in_q[grant*W +: W];
                ch     <= grant;
                rr_ptr <= (grant == CW'(NCH-1)) ? '0 : grant + CW'(1);
            end
            if (state == MUL1)
                p1 <= prod;
            if (state == MUL2) begin
                out_m      <= p1 - prod;
                out_ch     <= ch;
                i_last[ch] <= i_r;
                q_last[ch] <= q_r;
            end
            if (hist_clr) begin
                for (int k = 0; k < NCH; k++) begin
                    i_last[k] <= '0;
                    q_last[k] <= '0;
                end
            end
        end
    end
endmodule
